// File: rtl/parser_input_arb.sv
// Packet-level round-robin arbiter in front of the stream parser input port.
// Optional mid-packet stall timeout with abort/drain is enabled by PARSER_ARB_TIMEOUT_EN.
module parser_input_arb #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_val,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_W-1:0]             dst_data,
    output logic                          dst_val,
    output logic                          dst_last,
    input  logic                          dst_ready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned IdW = $clog2(NUM_SRC);

`ifdef PARSER_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StPass, StAbort, StDrain} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPass} state_e;
`endif

    state_e           state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [IdW-1:0]   req_idx;
    logic             req_found;
    logic [IdW-1:0]   next_ptr;

    // Round-robin search starting at rr_q, wrapping modulo NUM_SRC.
    always_comb begin
        int unsigned idx;
        req_found = 1'b0;
        req_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_q) + k) % NUM_SRC;
            if (!req_found && src_val[idx[IdW-1:0]]) begin
                req_found = 1'b1;
                req_idx   = idx[IdW-1:0];
            end
        end
    end

    assign next_ptr = (grant_q == IdW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

`ifdef PARSER_ARB_TIMEOUT_EN
    logic [CntW-1:0] stall_q;

    // Counts consecutive granted-source idle cycles inside a packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == StPass && !src_val[grant_q]) begin
            stall_q <= stall_q + 1'b1;
        end else begin
            stall_q <= '0;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        dst_data  = '0;
        dst_val   = 1'b0;
        dst_last  = 1'b0;
        src_ready = '0;
`ifdef PARSER_ARB_TIMEOUT_EN
        timeout_err = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_found) begin
                    grant_d = req_idx;
                    state_d = StPass;
                end
            end
            StPass: begin
                dst_data           = src_data[grant_q*DATA_W +: DATA_W];
                dst_val            = src_val[grant_q];
                dst_last           = src_last[grant_q];
                src_ready[grant_q] = dst_ready;
                if (src_val[grant_q] && src_last[grant_q] && dst_ready) begin
                    rr_d    = next_ptr;
                    state_d = StIdle;
                end
`ifdef PARSER_ARB_TIMEOUT_EN
                else if (!src_val[grant_q] && stall_q == CntW'(TIMEOUT_CYC - 1)) begin
                    state_d = StAbort;
                end
`endif
            end
`ifdef PARSER_ARB_TIMEOUT_EN
            // Synthetic zero last beat closes the packet at the parser.
            StAbort: begin
                dst_val  = 1'b1;
                dst_last = 1'b1;
                if (dst_ready) begin
                    timeout_err = 1'b1;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                src_ready[grant_q] = 1'b1;
                if (src_val[grant_q] && src_last[grant_q]) begin
                    rr_d    = next_ptr;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifndef PARSER_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != StIdle);

endmodule
